// File: rtl/seq_fifo_if.sv
// Host/DTU handshake bundle for seq_fifo; AW must match the FIFO's pointer width.
interface seq_fifo_if #(
  parameter int AW = 6
);
  logic          wr_en;
  logic [31:0]   wr_data;
  logic          full;
  logic          flush;
  logic          dtu_ready;
  logic [31:0]   dout;
  logic          dout_valid;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;

  modport master (
    output wr_en, wr_data, flush, dtu_ready,
    input  full, empty, count, dout, dout_valid, overflow
  );

  modport slave (
    input  wr_en, wr_data, flush, dtu_ready,
    output full, empty, count, dout, dout_valid, overflow
  );
endinterface

// File: rtl/seq_fifo.sv
// Circular nucleotide-word FIFO feeding a DTU with a one-cycle registered read port.
// Optional sticky write-when-full flag is built only when SEQ_FIFO_OVERFLOW_FLAG_EN is defined.
module seq_fifo #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input logic       clk,
  input logic       rst,
  seq_fifo_if.slave bus
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [31:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [AW:0]   count_s;
  logic          full_r;
  logic          empty_r;
  logic          dout_valid_r;
  logic [31:0]   dout_r;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;

  // Handshake decode on pre-edge state; a pop frees the slot a full-FIFO push needs.
  always_comb begin
    pop_s   = 1'b0;
    push_s  = 1'b0;
    drop_s  = 1'b0;
    count_s = count_r;
    pop_s   = bus.dtu_ready & ~empty_r;
    push_s  = bus.wr_en & (~full_r | pop_s);
    drop_s  = bus.wr_en & full_r & ~pop_s;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + (AW+1)'(1);
      2'b01:   count_s = count_r - (AW+1)'(1);
      default: count_s = count_r;
    endcase
  end

  // Pointer, occupancy and read-port state; flush outranks any same-cycle push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      count_r      <= {(AW+1){1'b0}};
      full_r       <= 1'b0;
      empty_r      <= 1'b1;
      dout_valid_r <= 1'b0;
      dout_r       <= 32'h0000_0000;
    end else if (bus.flush) begin
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      count_r      <= {(AW+1){1'b0}};
      full_r       <= 1'b0;
      empty_r      <= 1'b1;
      dout_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
        dout_r   <= mem_r[rd_ptr_r];
      end
      dout_valid_r <= pop_s;
      count_r      <= count_s;
      full_r       <= (count_s == DEPTH_C);
      empty_r      <= (count_s == {(AW+1){1'b0}});
    end
  end

  // Word storage; left uninitialised since reset only has to discard the pointers.
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush && push_s) begin
      mem_r[wr_ptr_r] <= bus.wr_data;
    end
  end

`ifdef SEQ_FIFO_OVERFLOW_FLAG_EN
  logic overflow_r;

  // Sticky dropped-write flag, cleared only by reset or flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (bus.flush) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end
  end

  assign bus.overflow = overflow_r;
`else
  logic unused_drop_s;
  assign unused_drop_s = drop_s;
  assign bus.overflow  = 1'b0;
`endif

  assign bus.full       = full_r;
  assign bus.empty      = empty_r;
  assign bus.count      = count_r;
  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;

endmodule
